d8_fetch: RTL

//  Instruction fetch unit of the dumb8 core: owns the PC, issues reads to the synchronous program memory and hands words to decode.

---
 rtl/d8_fetch_pkg.sv | 24 ++
 rtl/d8_fetch_if.sv | 31 +++
 rtl/d8_fetch_skid.sv | 54 +++++
 rtl/d8_fetch.sv | 132 +++++++++++++
 4 files changed

// File: rtl/d8_fetch_pkg.sv
// Shared widths, opcode constants and fetch FSM encoding for the dumb8 fetch unit.
package d8_fetch_pkg;

    localparam int D8_ADDR_W  = 8;
    localparam int D8_INSTR_W = 16;
    localparam logic [7:0] D8_RESET_VEC = 8'h00;

    localparam logic [7:0] OP_JMP = 8'h09;
    localparam logic [7:0] OP_JZ  = 8'h0a;
    localparam logic [7:0] OP_HLT = 8'h0f;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    // Words held or owed to decode after this cycle's hand-off.
    function automatic logic [1:0] d8_occupancy(input logic ir_v, input logic sk_v,
                                                input logic req_v, input logic ir_rdy);
        return {1'b0, ir_v} + {1'b0, sk_v} + {1'b0, req_v} - {1'b0, ir_v & ir_rdy};
    endfunction

endpackage

// File: rtl/d8_fetch_if.sv
// Fetch-side bundle: jump/flush/halt controls, program memory port and decode hand-off.
interface d8_fetch_if
    import d8_fetch_pkg::*;
#(
    parameter int ADDR_W  = D8_ADDR_W,
    parameter int INSTR_W = D8_INSTR_W
) ();

    logic               load;
    logic [ADDR_W-1:0]  mem_addr;
    logic               li_di_rst;
    logic               halt;
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic               ir_ready;

    modport master (
        input  load, mem_addr, li_di_rst, halt, imem_data, ir_ready,
        output imem_en, imem_addr, ir, ir_pc, ir_valid
    );

    modport slave (
        output load, mem_addr, li_di_rst, halt, imem_data, ir_ready,
        input  imem_en, imem_addr, ir, ir_pc, ir_valid
    );

endinterface

// File: rtl/d8_fetch_skid.sv
// One-entry skid buffer holding a returned word and its address while decode stalls.
module d8_fetch_skid #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               push,
    input  logic               pop,
    input  logic               clear,
    input  logic [INSTR_W-1:0] in_word,
    input  logic [ADDR_W-1:0]  in_pc,
    output logic [INSTR_W-1:0] out_word,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               valid
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    // Push wins over pop so a simultaneous drain-and-refill keeps the new word.
    always_comb begin
        valid_d = valid_q;
        word_d  = word_q;
        pc_d    = pc_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
            word_d  = in_word;
            pc_d    = in_pc;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            pc_q    <= pc_d;
        end
    end

    assign out_word = word_q;
    assign out_pc   = pc_q;
    assign valid    = valid_q;

endmodule

// File: rtl/d8_fetch.sv
// dumb8 instruction fetch: PC, boot/run/halt FSM, one outstanding memory read,
// ir register plus skid so decode back-pressure never loses a returning word.
module d8_fetch
    import d8_fetch_pkg::*;
#(
    parameter int ADDR_W  = D8_ADDR_W,
    parameter int INSTR_W = D8_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(D8_RESET_VEC)
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    d8_fetch_if.master  bus
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               req_valid_q, req_valid_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               req_epoch_q, req_epoch_d;
    logic               epoch_q, epoch_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;

    logic               accept, flush, issue, fetch, ret, ir_free;
    logic [1:0]         occ;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               sk_valid, sk_push, sk_pop;
    logic [INSTR_W-1:0] sk_word;
    logic [ADDR_W-1:0]  sk_pc;

    assign accept     = ir_valid_q & bus.ir_ready;
    assign flush      = bus.li_di_rst | bus.load;
    assign occ        = d8_occupancy(ir_valid_q, sk_valid, req_valid_q, bus.ir_ready);
    assign issue      = (state_q == ST_RUN) && (occ < 2'd2) && !bus.halt;
    assign fetch      = sys_rst & (issue | (bus.load & (state_q != ST_BOOT)));
    assign fetch_addr = bus.load ? bus.mem_addr : pc_q;

    // A returning word is kept only if no flush has happened since it was issued.
    assign ret     = req_valid_q & (req_epoch_q == epoch_q) & !flush;
    assign ir_free = !ir_valid_q | bus.ir_ready;
    assign sk_pop  = ir_free & sk_valid & !flush;
    assign sk_push = ret & (!ir_free | sk_valid);

    d8_fetch_skid #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .push     (sk_push),
        .pop      (sk_pop),
        .clear    (flush),
        .in_word  (bus.imem_data),
        .in_pc    (req_pc_q),
        .out_word (sk_word),
        .out_pc   (sk_pc),
        .valid    (sk_valid)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (bus.halt && !bus.load) state_d = ST_HALT;
            ST_HALT: if (bus.load) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    always_comb begin
        pc_d        = fetch ? fetch_addr + ADDR_W'(1) : pc_q;
        epoch_d     = flush ? ~epoch_q : epoch_q;
        req_valid_d = fetch;
        req_pc_d    = fetch ? fetch_addr : req_pc_q;
        req_epoch_d = fetch ? epoch_d : req_epoch_q;

        ir_valid_d = ir_valid_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        // The skid is always older than the word coming back from memory.
        if (flush) begin
            ir_valid_d = 1'b0;
        end else if (ir_free) begin
            if (sk_valid) begin
                ir_valid_d = 1'b1;
                ir_d       = sk_word;
                ir_pc_d    = sk_pc;
            end else if (ret) begin
                ir_valid_d = 1'b1;
                ir_d       = bus.imem_data;
                ir_pc_d    = req_pc_q;
            end else begin
                ir_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_VEC;
            req_valid_q <= 1'b0;
            req_pc_q    <= '0;
            req_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            req_epoch_q <= req_epoch_d;
            epoch_q     <= epoch_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
        end
    end

    assign bus.imem_en   = fetch;
    assign bus.imem_addr = fetch_addr;
    assign bus.ir        = ir_q;
    assign bus.ir_pc     = ir_pc_q;
    assign bus.ir_valid  = ir_valid_q;

    logic unused_accept;
    assign unused_accept = accept;

endmodule
